// File: rtl/load_store_unit.sv
// Load/store sequencer for the 16-bit byte-addressed data memory port.
// Optional LSU_ALIGN_CHECK_EN rejects odd-address word accesses with err.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [15:0] base,
    input  logic [4:0]  imm,
    input  logic [15:0] sdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [15:0] ldata,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic        mem_rd,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);
    localparam int unsigned DW   = 16;
    localparam int unsigned IMMW = 5;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD1  = 3'd1;
    localparam logic [2:0] S_RD2  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [1:0] OP_LW  = 2'b00;
    localparam logic [1:0] OP_LBS = 2'b01;
    localparam logic [1:0] OP_LBU = 2'b10;
    localparam logic [1:0] OP_SW  = 2'b11;

    logic [2:0]    state, state_d;
    logic [1:0]    op_q, op_d;
    logic          ready_d, done_d, err_d, mem_we_d, mem_rd_d;
    logic [DW-1:0] ldata_d, addr_d, wdata_d;
    logic [DW-1:0] ea_c;
    logic          misalign_c;

    assign ea_c = base + {{(DW-IMMW){imm[IMMW-1]}}, imm};

`ifdef LSU_ALIGN_CHECK_EN
    assign misalign_c = ea_c[0] && (op == OP_LW || op == OP_SW);
`else
    assign misalign_c = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // Next state and next value of every registered output
    always_comb begin
        state_d  = state;
        op_d     = op_q;
        ready_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        mem_we_d = 1'b0;
        mem_rd_d = 1'b0;
        ldata_d  = ldata;
        addr_d   = mem_addr;
        wdata_d  = mem_wdata;
        case (state)
            S_IDLE: begin
                if (req) begin
                    op_d    = op;
                    addr_d  = ea_c;
                    wdata_d = sdata;
                    if (misalign_c) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (op == OP_SW) begin
                        state_d  = S_WR;
                        mem_we_d = 1'b1;
                    end else begin
                        state_d  = S_RD1;
                        mem_rd_d = 1'b1;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            S_RD1: begin
                state_d  = S_RD2;
                mem_rd_d = 1'b1;
            end
            S_RD2: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                case (op_q)
                    OP_LBS:  ldata_d = {{8{mem_rdata[7]}}, mem_rdata[7:0]};
                    OP_LBU:  ldata_d = {8'h00, mem_rdata[7:0]};
                    default: ldata_d = mem_rdata;
                endcase
            end
            S_WR: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // Output and datapath registers; strobes clear at once on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_LW;
            ready     <= 1'b1;
            done      <= 1'b0;
            mem_we    <= 1'b0;
            mem_rd    <= 1'b0;
            ldata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            op_q      <= op_d;
            ready     <= ready_d;
            done      <= done_d;
            mem_we    <= mem_we_d;
            mem_rd    <= mem_rd_d;
            ldata     <= ldata_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
        end
    end

`ifdef LSU_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= err_d;
    end
`else
    assign err = 1'b0;
    logic unused_err_d;
    assign unused_err_d = err_d;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random ops
// against a transaction-level memory model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [1:0]  op;
    logic [15:0] base;
    logic [4:0]  imm;
    logic [15:0] sdata;
    logic        ready, done, err;
    logic [15:0] ldata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_rd;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] exp_ldata;
    int          n_assert = 0;
    int          n_fail   = 0;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .base(base), .imm(imm),
        .sdata(sdata), .ready(ready), .done(done), .err(err), .ldata(ldata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = {mem[16'(mem_addr + 16'd1)], mem[mem_addr]};

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr]                <= mem_wdata[7:0];
            mem[16'(mem_addr + 16'd1)]   <= mem_wdata[15:8];
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int w = 0;
        while (ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("wait_ready", 16'(ready), 16'd1);
    endtask

    function automatic logic [15:0] model_ea(input logic [15:0] b, input logic [4:0] i);
        int off;
        off = (int'(i) >= 16) ? int'(i) - 32 : int'(i);
        return 16'((int'(b) + off + 65536) % 65536);
    endfunction

    // One request through the DUT, checked cycle by cycle against the model
    task automatic run_op(input logic [1:0] o, input logic [15:0] b,
                          input logic [4:0] i, input logic [15:0] sd);
        logic [15:0] ea, a1;
        bit is_load, bad;
        int done_cyc, sb;
        ea = model_ea(b, i);
        a1 = 16'((int'(ea) + 1) % 65536);
        is_load = (o != 2'b11);
`ifdef LSU_ALIGN_CHECK_EN
        bad = ea[0] && (o == 2'b00 || o == 2'b11);
`else
        bad = 1'b0;
`endif
        done_cyc = bad ? 1 : (is_load ? 3 : 2);
        if (!bad) begin
            case (o)
                2'b00: exp_ldata = {ref_mem[a1], ref_mem[ea]};
                2'b01: begin
                    sb = (ref_mem[ea] >= 8'd128) ? int'(ref_mem[ea]) - 256 : int'(ref_mem[ea]);
                    exp_ldata = 16'(sb);
                end
                2'b10: exp_ldata = 16'(ref_mem[ea]);
                default: begin
                    ref_mem[ea] = sd[7:0];
                    ref_mem[a1] = sd[15:8];
                end
            endcase
        end
        wait_ready();
        req = 1'b1; op = o; base = b; imm = i; sdata = sd;
        tick();
        req = 1'b0;
        for (int c = 1; c <= done_cyc; c++) begin
            chk($sformatf("rd_c%0d", c), 16'(mem_rd), 16'(!bad && is_load && c <= 2));
            chk($sformatf("we_c%0d", c), 16'(mem_we), 16'(!bad && !is_load && c == 1));
            chk($sformatf("done_c%0d", c), 16'(done), 16'(c == done_cyc));
            chk($sformatf("addr_c%0d", c), mem_addr, ea);
            if (mem_we) chk("wdata", mem_wdata, sd);
            if (c == done_cyc) begin
                chk("err", 16'(err), 16'(bad));
                chk("ldata", ldata, exp_ldata);
            end else begin
                tick();
            end
        end
        tick();
        chk("ready_after", 16'(ready), 16'd1);
        chk("done_after", 16'(done), 16'd0);
    endtask

    initial begin
        int dones, wes;
        logic [7:0] save0, save1;
        rst_n = 1'b0; req = 1'b0; op = 2'b00; base = '0; imm = '0; sdata = '0;
        for (int a = 0; a < 65536; a++) begin
            mem[a] = 8'($urandom);
            ref_mem[a] = mem[a];
        end
        mem[0] = 8'd50;  ref_mem[0] = 8'd50;
        mem[1] = 8'd200; ref_mem[1] = 8'd200;
        exp_ldata = '0;
        #12;
        chk("rst_ready", 16'(ready), 16'd1);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        chk("rst_strobes", 16'({mem_we, mem_rd}), 16'd0);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_wdata", mem_wdata, 16'h0000);
        chk("rst_ldata", ldata, 16'h0000);
        @(negedge clk); rst_n = 1'b1;
        tick();

        run_op(2'b00, 16'd0, 5'd0, 16'd0);
        chk("tp_lw0", ldata, 16'hC832);
        run_op(2'b01, 16'd2, 5'b11111, 16'd0);
        chk("tp_lbs", ldata, 16'hFFC8);
        run_op(2'b10, 16'd2, 5'b11111, 16'd0);
        chk("tp_lbu", ldata, 16'h00C8);
        run_op(2'b11, 16'd26, 5'd4, 16'h1234);
        chk("tp_sw_ldata_held", ldata, 16'h00C8);
        run_op(2'b00, 16'd30, 5'd0, 16'd0);
        chk("tp_lw30", ldata, 16'h1234);
        run_op(2'b00, 16'hFFFF, 5'd1, 16'd0);
        chk("tp_wrap", ldata, 16'hC832);
        run_op(2'b00, 16'd3, 5'd0, 16'd0);
        run_op(2'b11, 16'd40, 5'd1, 16'hBEEF);
        run_op(2'b01, 16'd5, 5'd0, 16'd0);

        // Request held high: second acceptance on the first IDLE cycle after DONE
        wait_ready();
        req = 1'b1; op = 2'b00; base = 16'd0; imm = 5'd0;
        tick();
        dones = 0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 5) req = 1'b0;
            if (done === 1'b1) dones++;
            if (c == 4) chk("held_ready_c4", 16'(ready), 16'd1);
            if (c == 7) chk("held_done_c7", 16'(done), 16'd1);
            if (c < 7) tick();
        end
        chk("held_dones", 16'(dones), 16'd2);
        chk("held_ldata", ldata, 16'hC832);
        exp_ldata = 16'hC832;

        // Request pulsed during RD2 is dropped
        wait_ready();
        req = 1'b1; op = 2'b10; base = 16'd2; imm = 5'b11111;
        tick();
        req = 1'b0;
        tick();
        req = 1'b1; op = 2'b11; base = 16'd40; imm = 5'd0; sdata = 16'hFFFF;
        dones = 0; wes = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            req = 1'b0;
            if (done === 1'b1) dones++;
            if (mem_we === 1'b1) wes++;
        end
        chk("rd2_req_dones", 16'(dones), 16'd1);
        chk("rd2_req_wes", 16'(wes), 16'd0);
        chk("rd2_req_ldata", ldata, 16'h00C8);
        exp_ldata = 16'h00C8;

        // Reset during RD1 aborts the load without a done
        wait_ready();
        req = 1'b1; op = 2'b00; base = 16'd0; imm = 5'd0;
        tick();
        req = 1'b0;
        chk("rst_rd1_rd_before", 16'(mem_rd), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_rd1_rd", 16'(mem_rd), 16'd0);
        chk("rst_rd1_we", 16'(mem_we), 16'd0);
        tick();
        @(negedge clk); rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        chk("rst_rd1_dones", 16'(dones), 16'd0);
        chk("rst_rd1_ready", 16'(ready), 16'd1);
        chk("rst_rd1_ldata", ldata, 16'h0000);
        exp_ldata = 16'h0000;

        // Reset during WR suppresses the write
        save0 = mem[100]; save1 = mem[101];
        wait_ready();
        req = 1'b1; op = 2'b11; base = 16'd100; imm = 5'd0; sdata = 16'hA55A;
        tick();
        req = 1'b0;
        chk("rst_wr_we_before", 16'(mem_we), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_wr_we", 16'(mem_we), 16'd0);
        tick();
        @(negedge clk); rst_n = 1'b1;
        tick(); tick();
        chk("rst_wr_mem", {mem[101], mem[100]}, {save1, save0});
        chk("rst_wr_done", 16'(done), 16'd0);

        for (int n = 0; n < 60; n++) begin
            logic [15:0] b;
            b = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
            run_op(2'($urandom), b, 5'($urandom), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side memory access controller driving the byte-addressed data memory port (`we`, `rd`, `addr`, `writeData`, `readData`) on behalf of the multicycle datapath. It accepts one load/store request at a time from the control unit and computes the effective address as base plus sign-extended 5-bit immediate. It sequences the memory read/write strobes and returns word, signed-byte or unsigned-byte load data with a single-cycle completion pulse.

## Interface
- No parameters; data and address widths are fixed at 16 bits.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  request strobe; sampled only when `ready`=1.
- `op`  in  2  00 LW, 01 LBs, 10 LBu, 11 SW.
- `base`  in  16  base register value (Rs1).
- `imm`  in  5  signed offset (immI).
- `sdata`  in  16  store data (Rs2/Rd value).
- `ready`  out  1  high in IDLE only.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`; misaligned word access.
- `ldata`  out  16  load result; held until the next load's `done`.
- `mem_addr`  out  16  byte address to data memory.
- `mem_we`  out  1  write strobe.
- `mem_rd`  out  1  read strobe.
- `mem_wdata`  out  16  write data; low byte stored at `mem_addr`, high byte at `mem_addr+1`.
- `mem_rdata`  in  16  {mem[addr+1], mem[addr]} from data memory.

## Operation
- States: IDLE, RD1, RD2, WR, DONE.
- IDLE: on `req`, latch `op` and `sdata`; compute `ea = base + {{11{imm[4]}},imm}` modulo 2^16, so wrap-around is silent; latch `ea` into `mem_addr`.
  - If `op` is LW/LBs/LBu, go to RD1.
  - If `op` is SW, go to WR.
  - If misaligned (see Configuration), go to DONE with `err`=1.
- RD1: `mem_rd`=1; go to RD2.
- RD2: `mem_rd`=1; sample `mem_rdata` at the end of the cycle; go to DONE.
  - LW: `ldata`=`mem_rdata`.
  - LBs: `ldata`={{8{mem_rdata[7]}},mem_rdata[7:0]}.
  - LBu: `ldata`={8'h00,mem_rdata[7:0]}.
- WR: `mem_we`=1 and `mem_wdata`=latched `sdata` for exactly one cycle; go to DONE.
- DONE: `done`=1; go to IDLE.
- `req` outside IDLE is ignored and is not queued.
- `mem_we` and `mem_rd` are never high in the same cycle.
- SW and error completions leave `ldata` unchanged.
- Reset values: state IDLE, `ready`=1, and `done`, `err`, `mem_we`, `mem_rd`=0; `mem_addr`, `mem_wdata`, `ldata`=16'h0000.

## Timing
- Request accepted at edge T, where `req`=1 and `ready`=1.
- Load: `mem_rd` is high in cycles T+1 and T+2; `done` is high in T+3 with `ldata` valid; `ready` returns in T+4.
- Store: `mem_we` is high in T+1; `done` is high in T+2.
- Error: `done` and `err` are high in T+1; no memory strobe is issued.
- A back-to-back `req` held high is accepted on the first IDLE cycle after DONE.
- `mem_addr` is stable from T+1 through DONE.
- Asserting `rst_n`=0 mid-operation immediately clears `mem_we` and `mem_rd`, with no partial write completed after reset assertion, and returns to IDLE; no `done` is emitted for the aborted request.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined: LW or SW with `ea[0]`=1 performs no memory access and completes through DONE with `err`=1.
- `LSU_ALIGN_CHECK_EN` undefined: no alignment check is made; LW and SW at odd addresses access bytes `ea` and `ea+1`; `err` is tied to 0.
- Byte loads are never misaligned under either setting.

## Test plan
- Memory[0]=8'd50 and memory[1]=8'd200; LW with `base`=0, `imm`=0 -> `mem_rd` high for 2 cycles, `done` at T+3, `ldata`=16'hC832.
- LBs with `base`=2, `imm`=5'b11111 (ea=1) -> `ldata`=16'hFFC8; LBu with the same address -> `ldata`=16'h00C8.
- SW with `base`=26, `imm`=4, `sdata`=16'h1234 -> `mem_we` for one cycle at `mem_addr`=30, `mem_wdata`=16'h1234; a following LW at 30 returns 16'h1234.
- LW with `base`=16'hFFFF, `imm`=1 -> `mem_addr`=16'h0000 (wrap) -> `ldata`=16'hC832.
- Macro defined, LW at ea=3 -> `done`=`err`=1 at T+1, `mem_rd` never asserted, `ldata` unchanged. Macro undefined, same request -> normal read returning {mem[4],mem[3]}.
- `rst_n` pulsed low during RD1 of a load, with `req` also pulsed during RD2 of a separate load -> reset: strobes drop immediately, no `done`, `ready`=1 after release. Pulsed `req` during RD2: ignored, only one `done` pulse.
